div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Port clock  input  1  rising-edge system clock; sole clock of the block.
REQ-003 Port clear_n  input  1  asynchronous active-low reset.
REQ-004 Port start  input  1  request to begin a division; sampled on the rising edge of clock.
REQ-005 Port Ra  input  WIDTH  signed dividend, two's complement; sampled with start.
REQ-006 Port Rb  input  WIDTH  signed divisor, two's complement; sampled with start.
REQ-007 Port busy  output  1  high while a division is in progress.
REQ-008 Port done  output  1  single-cycle pulse marking valid results.
REQ-009 Port LO  output  WIDTH  quotient.
REQ-010 Port HI  output  WIDTH  remainder.
REQ-011 Port div_zero  output  1  high with done when Rb was zero; held until the next accepted start.

Function
REQ-012 The block SHALL use states IDLE, RUN, FIX and DONE.
REQ-013 In IDLE with start=1, the block SHALL latch Ra and Rb, record the operand signs, load their magnitudes, clear div_zero, and go to RUN with a step counter of 0.
- Exception: if Rb=0, it SHALL instead go directly to DONE.
REQ-014 In IDLE with start=0, the block SHALL hold all outputs unchanged.
REQ-015 RUN SHALL perform one restoring-division step per clock, most significant dividend bit first, using a WIDTH+1-bit partial remainder.
REQ-016 RUN SHALL last exactly WIDTH cycles, then go to FIX.
REQ-017 FIX SHALL apply signs in one cycle and go to DONE.
- Quotient is negated when the operand signs differ.
- Remainder is negated when Ra was negative.
REQ-018 Division SHALL truncate toward zero; the remainder takes the sign of the dividend, and Ra = LO*Rb + HI holds modulo 2^WIDTH.
REQ-019 The magnitude of the most negative value (0x80000000 for WIDTH=32) SHALL be treated as unsigned 2^(WIDTH-1).
- Hence 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0 (wrap, no flag).
REQ-020 Divide by zero SHALL produce LO = all ones, HI = Ra, div_zero=1.
REQ-021 DONE SHALL assert done for exactly one cycle and return to IDLE on the next edge.
REQ-022 Latency SHALL be as follows, counted from the edge at which start was accepted:
- Nonzero divisor: done is high in the cycle beginning WIDTH+2 edges after that edge (34 for WIDTH=32).
- Zero divisor: done is high in the cycle beginning 1 edge after that edge.
REQ-023 busy SHALL be 1 in RUN, FIX and DONE, and 0 in IDLE.
REQ-024 start SHALL be ignored whenever busy=1; Ra and Rb changes during busy SHALL have no effect.
REQ-025 Back-to-back operation: start high during the DONE cycle SHALL be ignored; start is accepted on the first IDLE cycle.
REQ-026 LO and HI SHALL update only on the FIX-to-DONE transition (or the IDLE-to-DONE transition for divide by zero), and SHALL remain stable until the next result.

Reset
REQ-027 While clear_n=0, the block SHALL asynchronously force state IDLE, busy=0, done=0, div_zero=0, LO=0, HI=0, and step counter=0.
REQ-028 Reset asserted mid-division SHALL abort the operation; no done pulse SHALL follow.
REQ-029 After clear_n deasserts, the first start SHALL be accepted on the first rising edge with clear_n=1.

Verification
REQ-030 Ra=100, Rb=7, start pulsed one cycle -> busy high for 34 cycles; done pulses at cycle 34; LO=0x0000000E, HI=0x00000002, div_zero=0.
REQ-031 Ra=0xFFFFFF9C (-100), Rb=7 -> LO=0xFFFFFFF2 (-14), HI=0xFFFFFFFE (-2).
- Ra=100, Rb=0xFFFFFFF9 (-7) -> LO=0xFFFFFFF2, HI=0x00000002.
REQ-032 Ra=0x12345678, Rb=0 -> done at cycle 1; LO=0xFFFFFFFF, HI=0x12345678, div_zero=1.
- div_zero clears on the next accepted start.
REQ-033 Ra=0x80000000, Rb=0xFFFFFFFF -> LO=0x80000000, HI=0, div_zero=0.
REQ-034 start re-pulsed with new operands at cycle 10 of a 100/7 division -> ignored; the result is still LO=14, HI=2 at cycle 34.
REQ-035 clear_n pulsed low at cycle 15 of a division -> busy, done and LO/HI are 0 immediately with no done pulse.
- A subsequent Ra=9, Rb=3 -> LO=3, HI=0 after 34 cycles.

Source files
------------

// File: rtl/div_seq.sv
// Sequential signed restoring divider: one quotient bit per clock, signs applied
// in a final fix-up cycle. Quotient truncates toward zero; remainder follows the dividend.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] Rb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] HI,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             neg_a, neg_q;
  logic [WIDTH-1:0] quo, dvs, rem;
  logic [WIDTH:0]   trial, diff;
  logic             fits, last_step;

  // The most negative value negates to itself, which reads correctly as unsigned 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_nxt = state;
    trial     = {rem, quo[WIDTH-1]};
    diff      = trial - {1'b0, dvs};
    fits      = ~diff[WIDTH];
    last_step = (cnt == CW'(WIDTH - 1));
    case (state)
      IDLE: if (start) state_nxt = (Rb == '0) ? DONE : RUN;
      RUN:  if (last_step) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      cnt      <= '0;
      neg_a    <= 1'b0;
      neg_q    <= 1'b0;
      quo      <= '0;
      dvs      <= '0;
      rem      <= '0;
      LO       <= '0;
      HI       <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            neg_a    <= Ra[WIDTH-1];
            neg_q    <= Ra[WIDTH-1] ^ Rb[WIDTH-1];
            quo      <= mag(Ra);
            dvs      <= mag(Rb);
            rem      <= '0;
            cnt      <= '0;
            div_zero <= 1'b0;
            if (Rb == '0) begin
              LO       <= '1;
              HI       <= Ra;
              div_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          // Shift the next dividend bit into the remainder; keep the difference only if it fits.
          rem <= fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], fits};
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          LO <= neg_q ? -quo : quo;
          HI <= neg_a ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Randomised scoreboard bench for div_seq: a driver queues expected results from an
// arithmetic model, a monitor pops and compares on every done pulse.
module tb_div_seq;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
  } res_t;

  logic         clock = 1'b0;
  logic         clear_n, start;
  logic [W-1:0] Ra, Rb, LO, HI;
  logic         busy, done, div_zero;

  res_t sd[$];
  res_t last_exp;
  int   checks = 0;
  int   errors = 0;

  div_seq #(.WIDTH(W)) dut (
    .clock(clock), .clear_n(clear_n), .start(start), .Ra(Ra), .Rb(Rb),
    .busy(busy), .done(done), .LO(LO), .HI(HI), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic at double width, which truncates toward zero.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t   r;
    longint sa, sb, q, m;
    if (b == '0) begin
      r.lo = '1;
      r.hi = a;
      r.dz = 1'b1;
    end else begin
      sa   = $signed(a);
      sb   = $signed(b);
      q    = sa / sb;
      m    = sa % sb;
      r.lo = q[W-1:0];
      r.hi = m[W-1:0];
      r.dz = 1'b0;
    end
    return r;
  endfunction

  // Monitor
  always @(negedge clock) begin
    res_t e;
    if (clear_n === 1'b1 && done === 1'b1) begin
      if (sd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        e = sd.pop_front();
        check("LO", LO, e.lo);
        check("HI", HI, e.hi);
        check("div_zero", div_zero, e.dz);
        check("busy_with_done", busy, 1);
      end
    end
  end

  // poke_at: cycle at which start is re-pulsed with junk; rst_at: cycle at which reset aborts.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int poke_at, input int rst_at);
    int   cyc, guard;
    res_t e;
    guard = 0;
    @(negedge clock);
    while (busy && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    check("idle_before_start", busy, 0);
    start = 1'b1;
    Ra    = a;
    Rb    = b;
    e     = model(a, b);
    @(posedge clock);
    sd.push_back(e);
    last_exp = e;
    cyc = 1;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    if (b != '0) check("div_zero_cleared", div_zero, 0);
    while (!done && cyc < 100) begin
      Ra    = $urandom;
      Rb    = $urandom;
      start = (cyc == poke_at);
      if (cyc == rst_at) begin
        clear_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_LO", LO, 0);
        check("abort_HI", HI, 0);
        check("abort_div_zero", div_zero, 0);
        void'(sd.pop_back());
        last_exp = '0;
        #1 clear_n = 1'b1;
        start = 1'b0;
        return;
      end
      @(posedge clock);
      cyc++;
      @(negedge clock);
    end
    start = 1'b0;
    check("latency", cyc, (b == '0) ? 1 : W + 2);
  endtask

  task automatic idle_hold();
    repeat (3) begin
      @(negedge clock);
      Ra = $urandom;
      Rb = $urandom;
    end
    check("hold_LO", LO, last_exp.lo);
    check("hold_HI", HI, last_exp.hi);
    check("hold_div_zero", div_zero, last_exp.dz);
  endtask

  task automatic back_to_back();
    res_t e;
    @(negedge clock);
    start = 1'b1;
    Ra    = 32'd50;
    Rb    = '0;
    e     = model(Ra, Rb);
    sd.push_back(e);
    sd.push_back(e);
    last_exp = e;
    @(posedge clock);
    @(negedge clock);
    check("b2b_first_done", done, 1);
    @(posedge clock);
    @(negedge clock);
    check("b2b_start_ignored_in_done", busy, 0);
    @(posedge clock);
    @(negedge clock);
    check("b2b_second_done", done, 1);
    start = 1'b0;
    @(negedge clock);
    check("b2b_back_idle", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    clear_n = 1'b0;
    start   = 1'b0;
    Ra      = '0;
    Rb      = '0;
    last_exp = '0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_LO", LO, 0);
    check("rst_HI", HI, 0);
    check("rst_div_zero", div_zero, 0);
    @(negedge clock);
    clear_n = 1'b1;

    do_op(32'd100, 32'd7, -1, -1);
    idle_hold();
    do_op(32'hFFFF_FF9C, 32'd7, -1, -1);
    do_op(32'd100, 32'hFFFF_FFF9, -1, -1);
    do_op(32'h1234_5678, 32'd0, -1, -1);
    idle_hold();
    do_op(32'd100, 32'd7, -1, -1);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    do_op(32'd100, 32'd7, 10, -1);
    idle_hold();
    back_to_back();
    do_op(32'd100, 32'd7, -1, 15);
    repeat (40) @(negedge clock);
    do_op(32'd9, 32'd3, -1, -1);

    for (int i = 0; i < 25; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'h8000_0000;
        3:       b = $urandom_range(1, 20);
        4:       b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      if (i % 7 == 0) a = 32'h8000_0000;
      do_op(a, b, -1, -1);
    end

    repeat (5) @(negedge clock);
    check("scoreboard_drained", sd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
